// File: rtl/tetris_pkg.sv
// Shared types for the tetris input front-end: command encoding, UART key
// codes, push-button indices, issue-FSM states and the key decoder.
package tetris_pkg;

    typedef enum logic [3:0] {
        NONE       = 4'd0,
        LEFT       = 4'd1,
        RIGHT      = 4'd2,
        DOWN       = 4'd3,
        DROP       = 4'd4,
        HOLD       = 4'd5,
        ROTATE     = 4'd6,
        ROTATE_REV = 4'd7,
        BAR        = 4'd8
    } control_type;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } issue_state_t;

    localparam logic [7:0] KEY_LEFT       = 8'h61;
    localparam logic [7:0] KEY_RIGHT      = 8'h64;
    localparam logic [7:0] KEY_DOWN       = 8'h73;
    localparam logic [7:0] KEY_DROP       = 8'h20;
    localparam logic [7:0] KEY_HOLD       = 8'h63;
    localparam logic [7:0] KEY_ROTATE     = 8'h77;
    localparam logic [7:0] KEY_ROTATE_REV = 8'h7A;
    localparam logic [7:0] KEY_BAR        = 8'h62;

    localparam int NUM_BTN    = 4;
    localparam int BTN_RIGHT  = 0;
    localparam int BTN_DOWN   = 1;
    localparam int BTN_ROTATE = 2;
    localparam int BTN_LEFT   = 3;

    // Unmapped bytes decode to NONE, which the caller treats as "ignore".
    function automatic control_type key_decode(input logic [7:0] key);
        control_type cmd;
        case (key)
            KEY_LEFT:       cmd = LEFT;
            KEY_RIGHT:      cmd = RIGHT;
            KEY_DOWN:       cmd = DOWN;
            KEY_DROP:       cmd = DROP;
            KEY_HOLD:       cmd = HOLD;
            KEY_ROTATE:     cmd = ROTATE;
            KEY_ROTATE_REV: cmd = ROTATE_REV;
            KEY_BAR:        cmd = BAR;
            default:        cmd = NONE;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/ctrl_arbiter_if.sv
// Command/UART bus between board-side producers and ctrl_arbiter.
interface ctrl_arbiter_if;
    import tetris_pkg::*;

    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        ready;
    control_type control;
    logic        overflow;

    modport master (output rx_valid, rx_data, ready, input control, overflow);
    modport slave  (input rx_valid, rx_data, ready, output control, overflow);

endinterface

// File: rtl/ctrl_arbiter_btn_debounce.sv
// One push-button: 2-FF synchroniser, debounce, press strobe and (with
// CTRL_REPEAT_EN defined) auto-repeat while held. DEBOUNCE_CYC must be >= 2.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYC     = 1_000_000,
    parameter int unsigned REPEAT_DELAY_CYC = 15_000_000,
    parameter int unsigned REPEAT_RATE_CYC  = 5_000_000,
    parameter bit          REPEAT_EN        = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic evt
);
    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYC + 1);

    logic            sync_1, sync_2, stable;
    logic [DB_W-1:0] db_cnt;
    logic            flip, rise, fall, rpt_fire;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= btn_raw;
            sync_2 <= sync_1;
        end
    end

    // db_cnt == 0 means idle; a differing input loads it and the stable
    // state flips when it reaches the terminal count of 1.
    assign flip = (sync_2 != stable) && (db_cnt == DB_W'(1));
    assign rise = flip && sync_2;
    assign fall = flip && !sync_2;

    always_ff @(posedge clk) begin
        if (reset) begin
            db_cnt <= '0;
            stable <= 1'b0;
        end else if (sync_2 == stable) begin
            db_cnt <= '0;
        end else if (flip) begin
            db_cnt <= '0;
            stable <= sync_2;
        end else if (db_cnt == '0) begin
            db_cnt <= DB_W'(DEBOUNCE_CYC - 1);
        end else begin
            db_cnt <= db_cnt - 1'b1;
        end
    end

`ifdef CTRL_REPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ?
                                      REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
    localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

    if (REPEAT_EN) begin : g_rpt
        logic [RPT_W-1:0] rpt_cnt;

        assign rpt_fire = stable && !fall && (rpt_cnt == RPT_W'(1));

        always_ff @(posedge clk) begin
            if (reset) begin
                rpt_cnt <= '0;
            end else if (rise) begin
                rpt_cnt <= RPT_W'(REPEAT_DELAY_CYC);
            end else if (!stable || fall) begin
                rpt_cnt <= '0;
            end else if (rpt_fire) begin
                rpt_cnt <= RPT_W'(REPEAT_RATE_CYC);
            end else if (rpt_cnt != '0) begin
                rpt_cnt <= rpt_cnt - 1'b1;
            end
        end
    end else begin : g_no_rpt
        assign rpt_fire = 1'b0;
    end
`else
    assign rpt_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            evt <= 1'b0;
        end else begin
            evt <= rise || rpt_fire;
        end
    end

endmodule

// File: rtl/ctrl_arbiter.sv
// Merges debounced push-buttons and decoded UART keys into a command FIFO and
// issues one command at a time to the tetris core. CTRL_REPEAT_EN adds auto-repeat.
//
// state    | meaning
// ST_IDLE  | waiting for a queued command while ready is high
// ST_ISSUE | control shows the popped command for this one cycle
// ST_GAP   | spacing cycle so the core can drop ready
module ctrl_arbiter
    import tetris_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC     = 1_000_000,
    parameter int unsigned REPEAT_DELAY_CYC = 15_000_000,
    parameter int unsigned REPEAT_RATE_CYC  = 5_000_000,
    parameter int unsigned FIFO_DEPTH       = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    usr_btn,
    ctrl_arbiter_if.slave bus
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [NUM_BTN-1:0] btn_evt, btn_pend, grant_btn;
    control_type        rx_cmd, hold_cmd, push_cmd, control_nx;
    logic               rx_hit, hold_full, grant_uart, push, pop;
    control_type        fifo_mem [FIFO_DEPTH];
    logic [AW:0]        wr_ptr, rd_ptr;
    logic               fifo_full, fifo_empty;
    issue_state_t       state, state_nx;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYC     (DEBOUNCE_CYC),
            .REPEAT_DELAY_CYC (REPEAT_DELAY_CYC),
            .REPEAT_RATE_CYC  (REPEAT_RATE_CYC),
            .REPEAT_EN        (i != BTN_ROTATE)
        ) u_btn (
            .clk     (clk),
            .reset   (reset),
            .btn_raw (usr_btn[i]),
            .evt     (btn_evt[i])
        );
    end

    assign rx_cmd = key_decode(bus.rx_data);
    assign rx_hit = bus.rx_valid && (rx_cmd != NONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_full    <= 1'b0;
            hold_cmd     <= NONE;
            bus.overflow <= 1'b0;
        end else begin
            bus.overflow <= rx_hit && hold_full;
            if (rx_hit && !hold_full) begin
                hold_full <= 1'b1;
                hold_cmd  <= rx_cmd;
            end else if (grant_uart) begin
                hold_full <= 1'b0;
            end
        end
    end

    // An event arriving while its pending bit is set is merged into it.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_pend <= '0;
        end else begin
            btn_pend <= (btn_pend & ~grant_btn) | (btn_evt & ~btn_pend);
        end
    end

    always_comb begin
        push       = 1'b0;
        push_cmd   = NONE;
        grant_uart = 1'b0;
        grant_btn  = '0;
        if (!fifo_full) begin
            if (hold_full) begin
                push       = 1'b1;
                push_cmd   = hold_cmd;
                grant_uart = 1'b1;
            end else if (btn_pend[BTN_LEFT]) begin
                push                = 1'b1;
                push_cmd            = LEFT;
                grant_btn[BTN_LEFT] = 1'b1;
            end else if (btn_pend[BTN_ROTATE]) begin
                push                  = 1'b1;
                push_cmd              = ROTATE;
                grant_btn[BTN_ROTATE] = 1'b1;
            end else if (btn_pend[BTN_DOWN]) begin
                push                = 1'b1;
                push_cmd            = DOWN;
                grant_btn[BTN_DOWN] = 1'b1;
            end else if (btn_pend[BTN_RIGHT]) begin
                push                 = 1'b1;
                push_cmd             = RIGHT;
                grant_btn[BTN_RIGHT] = 1'b1;
            end
        end
    end

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= push_cmd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_comb begin
        state_nx   = state;
        pop        = 1'b0;
        control_nx = NONE;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty && bus.ready) begin
                    state_nx   = ST_ISSUE;
                    pop        = 1'b1;
                    control_nx = fifo_mem[rd_ptr[AW-1:0]];
                end
            end
            ST_ISSUE: state_nx = ST_GAP;
            ST_GAP:   state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            bus.control <= NONE;
        end else begin
            state       <= state_nx;
            bus.control <= control_nx;
        end
    end

endmodule
